// File: rtl/usb_rx_deserializer.sv
// USB receive front end: line-state decode, NRZI, SYNC/EOP detection, bit unstuffing, LSB-first bytes.
// Define USB_RX_PID_CHECK_EN to add a PID complement check on the first byte of each packet.
module usb_rx_deserializer #(
    parameter bit LOW_SPEED      = 1'b0,
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int ERR_IDLE_BITS  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       usb_dp,
    input  logic       usb_dn,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       pkt_active,
    output logic       pkt_end,
    output logic       rx_error,
    output logic       pid_err
);
    localparam int              JW       = $clog2(ERR_IDLE_BITS + 1);
    localparam logic [3:0]      SYNC_MIN = 4'(SYNC_MIN_ZEROS);
    localparam logic [JW-1:0]   J_LAST   = JW'(ERR_IDLE_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

    state_t        state, state_d;
    logic          prev_j, prev_j_d;
    logic [3:0]    zero_cnt, zero_cnt_d;
    logic [2:0]    ones_cnt, ones_cnt_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [1:0]    se0_cnt, se0_cnt_d;
    logic [JW-1:0] j_cnt, j_cnt_d;
    logic [7:0]    sreg, sreg_d, data_out_d, byte_next;
    logic          data_valid_d, pkt_active_d, pkt_end_d, rx_error_d, go_err;
    logic          line_j, line_k, se0, se1, nrzi_bit;
`ifdef USB_RX_PID_CHECK_EN
    logic          first_byte, first_byte_d, pid_err_d;
`endif

    // Low speed swaps the differential polarity of J and K.
    assign line_j    = LOW_SPEED ? (!usb_dp && usb_dn) : (usb_dp && !usb_dn);
    assign line_k    = LOW_SPEED ? (usb_dp && !usb_dn) : (!usb_dp && usb_dn);
    assign se0       = !usb_dp && !usb_dn;
    assign se1       = usb_dp && usb_dn;
    assign nrzi_bit  = (line_j == prev_j);
    assign byte_next = {nrzi_bit, sreg[7:1]};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d      = state;
        prev_j_d     = prev_j;
        zero_cnt_d   = zero_cnt;
        ones_cnt_d   = ones_cnt;
        bit_cnt_d    = bit_cnt;
        se0_cnt_d    = se0_cnt;
        j_cnt_d      = j_cnt;
        sreg_d       = sreg;
        data_out_d   = data_out;
        pkt_active_d = pkt_active;
        data_valid_d = 1'b0;
        pkt_end_d    = 1'b0;
        rx_error_d   = 1'b0;
        go_err       = 1'b0;
`ifdef USB_RX_PID_CHECK_EN
        first_byte_d = first_byte;
        pid_err_d    = 1'b0;
`endif
        if (bit_en) begin
            if (line_j || line_k) prev_j_d = line_j;
            unique case (state)
                S_IDLE: begin
                    if (line_k) begin
                        state_d    = S_SYNC;
                        zero_cnt_d = 4'd1;
                    end else if (se1) begin
                        go_err = 1'b1;
                    end
                end
                S_SYNC: begin
                    if (se0 || se1) begin
                        go_err = 1'b1;
                    end else if (!nrzi_bit) begin
                        if (zero_cnt != 4'hF) zero_cnt_d = zero_cnt + 4'd1;
                    end else if (zero_cnt >= SYNC_MIN) begin
                        state_d      = S_DATA;
                        pkt_active_d = 1'b1;
                        ones_cnt_d   = 3'd1;
                        bit_cnt_d    = 3'd0;
`ifdef USB_RX_PID_CHECK_EN
                        first_byte_d = 1'b1;
`endif
                    end else begin
                        go_err = 1'b1;
                    end
                end
                S_DATA: begin
                    if (se0) begin
                        state_d   = S_EOP;
                        se0_cnt_d = 2'd1;
                    end else if (se1) begin
                        go_err = 1'b1;
                    end else if (ones_cnt == 3'd6) begin
                        // Six ones in a row: this bit must be the stuffed zero and is discarded.
                        if (nrzi_bit) go_err = 1'b1;
                        else          ones_cnt_d = 3'd0;
                    end else begin
                        sreg_d     = byte_next;
                        bit_cnt_d  = bit_cnt + 3'd1;
                        ones_cnt_d = nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                        if (bit_cnt == 3'd7) begin
                            data_out_d   = byte_next;
                            data_valid_d = 1'b1;
`ifdef USB_RX_PID_CHECK_EN
                            pid_err_d    = first_byte && (byte_next[3:0] != ~byte_next[7:4]);
                            first_byte_d = 1'b0;
`endif
                        end
                    end
                end
                S_EOP: begin
                    if (se0) begin
                        if (se0_cnt >= 2'd2) begin
                            se0_cnt_d = 2'd3;
                            go_err    = 1'b1;
                        end else begin
                            se0_cnt_d = se0_cnt + 2'd1;
                        end
                    end else if (line_j && se0_cnt >= 2'd2 && bit_cnt == 3'd0) begin
                        pkt_end_d    = 1'b1;
                        pkt_active_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                S_ERROR: begin
                    if (!line_j) begin
                        j_cnt_d = '0;
                    end else if (j_cnt == J_LAST) begin
                        state_d  = S_IDLE;
                        prev_j_d = 1'b1;
                        j_cnt_d  = '0;
                    end else begin
                        j_cnt_d = j_cnt + JW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (go_err) begin
                state_d      = S_ERROR;
                rx_error_d   = 1'b1;
                pkt_active_d = 1'b0;
                j_cnt_d      = '0;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every one updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_j     <= 1'b1;
            zero_cnt   <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            se0_cnt    <= '0;
            j_cnt      <= '0;
            sreg       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            pkt_active <= 1'b0;
            pkt_end    <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            state      <= state_d;
            prev_j     <= prev_j_d;
            zero_cnt   <= zero_cnt_d;
            ones_cnt   <= ones_cnt_d;
            bit_cnt    <= bit_cnt_d;
            se0_cnt    <= se0_cnt_d;
            j_cnt      <= j_cnt_d;
            sreg       <= sreg_d;
            data_out   <= data_out_d;
            data_valid <= data_valid_d;
            pkt_active <= pkt_active_d;
            pkt_end    <= pkt_end_d;
            rx_error   <= rx_error_d;
        end
    end

`ifdef USB_RX_PID_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_byte <= 1'b0;
            pid_err    <= 1'b0;
        end else begin
            first_byte <= first_byte_d;
            pid_err    <= pid_err_d;
        end
    end
`else
    assign pid_err = 1'b0;
`endif

endmodule
